pulse_divider: RTL and testbench

Parametrised multi-channel clock divider and tick generator, successor to the single fixed divide-by-25,000,000 square-wave generator in the clock design. It has CH independent channels. Each channel has a run-time loadable divisor and produces two outputs: a 50%-duty divided square wave and a one-cycle tick strobe. It also supports enable and synchronous clear, and feeds the seconds/minutes counters and display-scan logic.

---
 rtl/pulse_divider.sv | 89 ++++++++
 tb/tb_pulse_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_divider.sv
// -----------------------------------------------------------------------------
// pulse_divider
//   Multi-channel clock divider / tick generator. Each channel owns a run-time
//   loadable divisor D and produces a one-cycle tick every D+1 enabled cycles
//   plus a 50%-duty square wave that toggles on every tick.
//
// Ports
//   clk     in   1         system clock, rising edge
//   rst     in   1         asynchronous active-high reset
//   en      in   1         count enable, shared by all channels
//   clr     in   1         synchronous restart of all channels (highest priority)
//   load    in   1         synchronous divisor load strobe
//   div_in  in   CH*WIDTH  packed divisors, channel i at [i*WIDTH +: WIDTH]
//   tick    out  CH        per-channel one-cycle terminal-count strobe
//   wave    out  CH        per-channel divided square wave
//
// All outputs come straight from flops; there is no input-to-output comb path.
// -----------------------------------------------------------------------------
module pulse_divider #(
    parameter int WIDTH       = 32,
    parameter int CH          = 2,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [CH*WIDTH-1:0]   div_in,
    output logic [CH-1:0]         tick,
    output logic [CH-1:0]         wave
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    genvar g;
    for (g = 0; g < CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_cnt;
        logic             r_tick;
        logic             r_wave;

        logic [WIDTH-1:0] w_div_new;
        logic             w_term;

        assign w_div_new = div_in[g*WIDTH +: WIDTH];

        // >= rather than == so a divisor lowered below the running count (or
        // a count left over from any path) restarts instead of wrapping.
        assign w_term = (r_cnt >= r_div);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_div  <= DEF_DIV;
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_wave <= 1'b0;
            end else if (clr) begin
                // clr restarts the channel; a simultaneous load still lands.
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_wave <= 1'b0;
                if (load) begin
                    r_div <= w_div_new;
                end
            end else if (load) begin
                // Partial count is discarded; wave phase is kept.
                r_div  <= w_div_new;
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (en) begin
                if (w_term) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_wave <= ~r_wave;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end

        assign tick[g] = r_tick;
        assign wave[g] = r_wave;
    end

endmodule

// File: tb/tb_pulse_divider.sv
// -----------------------------------------------------------------------------
// tb_pulse_divider
//   Scoreboard bench for pulse_divider (WIDTH=8, CH=2, DEFAULT_DIV=3).
//   The driver applies stimulus, advances an arithmetic reference model after
//   each rising edge and queues the expected {tick, wave}. A monitor on the
//   falling edge pops each entry and compares it with the DUT outputs.
//
//   Reference model per channel: k = enabled edges since the last restart
//   (reset/clr/load), D = divisor, base = wave level at the last restart.
//   tick = enabled edge and k is a nonzero multiple of D+1;
//   wave = base XOR parity of floor(k / (D+1)).
// -----------------------------------------------------------------------------
module tb_pulse_divider;

    localparam int WIDTH = 8;
    localparam int CH    = 2;
    localparam int DEFD  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                clr;
    logic                load;
    logic [CH*WIDTH-1:0] div_in;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       wave;

    pulse_divider #(
        .WIDTH      (WIDTH),
        .CH         (CH),
        .DEFAULT_DIV(DEFD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .load  (load),
        .div_in(div_in),
        .tick  (tick),
        .wave  (wave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] tick;
        logic [CH-1:0] wave;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int k    [CH];
    int dv   [CH];
    bit base [CH];
    bit mtick[CH];

    function automatic bit model_wave(input int c);
        return base[c] ^ (((k[c] / (dv[c] + 1)) % 2) == 1);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            k[c] = 0; dv[c] = DEFD; base[c] = 1'b0; mtick[c] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < CH; c++) begin
            int dnew;
            dnew = int'(div_in[c*WIDTH +: WIDTH]);
            if (clr) begin
                k[c] = 0; base[c] = 1'b0; mtick[c] = 1'b0;
                if (load) dv[c] = dnew;
            end else if (load) begin
                base[c] = model_wave(c);
                k[c] = 0; dv[c] = dnew; mtick[c] = 1'b0;
            end else if (en) begin
                k[c]++;
                mtick[c] = ((k[c] % (dv[c] + 1)) == 0);
            end else begin
                mtick[c] = 1'b0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            e.tick[c] = mtick[c];
            e.wave[c] = model_wave(c);
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (tick === e.tick) n_pass++;
            else $display("FAIL tick t=%0t actual=%b required=%b", $time, tick, e.tick);
            n_checks++;
            if (wave === e.wave) n_pass++;
            else $display("FAIL wave t=%0t actual=%b required=%b", $time, wave, e.wave);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic c, input logic l,
                        input logic [CH*WIDTH-1:0] d, input bit mid_rst);
        @(negedge clk);
        #1;
        rst = 1'b0; en = e; clr = c; load = l; div_in = d;
        @(posedge clk);
        #1;
        model_edge();
        if (mid_rst) begin
            // Assert reset between edges; outputs must clear before the next edge.
            #1;
            rst = 1'b1;
            model_reset();
        end
        sb_q.push_back(model_out());
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, div_in, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; div_in = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state observed while rst is held.
        sb_q.push_back(model_out());
        @(negedge clk);

        // Default divisors: ticks on edges 4, 8, 12.
        run(13, 1'b1);

        // Load {1, 5}; wave holds at the load edge.
        step(1'b1, 1'b0, 1'b1, {8'd1, 8'd5}, 1'b0);
        run(20, 1'b1);

        // Enable gating at cnt=2 with D=3.
        step(1'b1, 1'b1, 1'b1, {8'd3, 8'd3}, 1'b0);
        run(2, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);

        // Divisor 0 loaded together with clr.
        step(1'b1, 1'b1, 1'b1, {8'd0, 8'd0}, 1'b0);
        run(6, 1'b1);
        run(2, 1'b0);
        run(3, 1'b1);

        // Async reset mid-count: wave=1, cnt=2 after 6 enabled edges.
        step(1'b1, 1'b1, 1'b1, {8'd3, 8'd3}, 1'b0);
        run(5, 1'b1);
        step(1'b1, 1'b0, 1'b0, div_in, 1'b1);
        run(10, 1'b1);

        // Maximum divisor on channel 0, small one on channel 1.
        step(1'b1, 1'b0, 1'b1, {8'd2, 8'd255}, 1'b0);
        run(600, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic              re, rc, rl;
            logic [WIDTH-1:0]  d0, d1;
            re = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 59) == 0);
            rl = ($urandom_range(0, 29) == 0);
            d0 = WIDTH'($urandom_range(0, 7));
            d1 = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 255))
                                             : WIDTH'($urandom_range(0, 5));
            step(re, rc, rl, {d1, d0}, ($urandom_range(0, 499) == 0));
        end

        // Let the monitor drain the queue.
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0 pending", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
